host_if_burst: RTL and testbench
================================

Name: host_if_burst

Overview:
- Parametrised successor of the FX2-style GPIF host interface.
- Decodes the host state/ctl bus into endpoint/register address loads, single register get/set, and counted burst reads and writes toward the device register bus.
- Adds a read prefetch FIFO, a write transfer counter, optional register-address auto-increment, and configurable widths.
- Sits between the top-level IOBuf pad ring and the per-endpoint device decoders.

Parameters:
- DATA_W, 16, host data bus and register data width
- ADDR_W, 16, width of di_ep_addr and di_reg_addr
- TC_W, 16, width of the read and write transfer counters
- FIFO_DEPTH, 4, read prefetch FIFO entries; power of 2, at least 2
- AUTO_INC, 0, 1 = di_reg_addr increments after each burst access

Ports:
- if_clock  in  1  interface clock; all logic is on the rising edge
- resetb  in  1  asynchronous, active-low reset
- ctl  in  3  GPIF control; bit 1 = rdwr_b strobe
- state  in  4  host opcode
- data_in  in  DATA_W  pad input from IOBuf
- data_out  out  DATA_W  pad output to IOBuf
- data_oe  out  1  pad output enable
- rdy  out  1  ready to host
- di_ep_addr  out  ADDR_W  endpoint address
- di_reg_addr  out  ADDR_W  register address
- di_reg_data_in  out  DATA_W  write data to device
- di_reg_data_out  in  DATA_W  read data from device, valid 1 cycle after di_read
- di_write  out  1  write strobe, one cycle per word
- di_read  out  1  read strobe, one cycle per word
- di_reset  out  1  register-value reset pulse
- rd_ready  in  1  device can accept a read
- wr_ready  in  1  device can accept a write

Behaviour:
- Reset: all outputs, counters and FIFO pointers = 0.
- Input registering: state, ctl and data_in are registered once (state_q, ctl_q, data_q); rdwr_b = ctl_q[1]. A second stage state_qq detects opcode changes.
- Opcode change (state_q != state_qq):
  - clear di_read, di_write, di_reset and data_oe;
  - flush the FIFO and the in-flight flag;
  - counters are kept.
  - The new opcode acts from the following cycle.
- Opcodes:
  - 1 SETEP: rdy=1; on rdwr_b, di_ep_addr <= data_q.
  - 2 SETREG: rdy=1; on rdwr_b, di_reg_addr <= data_q.
  - 3 SETRVAL: rdy=wr_ready; on rdwr_b && wr_ready, di_write=1 and di_reg_data_in <= data_q.
  - 5 RESETRVAL: di_reset pulses high exactly one cycle after entry, then holds 0.
  - 6 GETRVAL: data_oe=1; data_out = di_reg_data_out; rdy=rd_ready; di_read = rdwr_b && rd_ready.
  - 7 RDTC: rdy=1; on rdwr_b, rd_tc <= data_q[TC_W-1:0] (zero-extended if TC_W > DATA_W).
  - 9 WRTC: rdy=1; on rdwr_b, wr_tc <= data_q likewise.
  - 4 RDDATA and 8 WRDATA: see below.
  - All others: idle, rdy=0.
- RDDATA (prefetch):
  - data_oe=1.
  - Issue di_read when rd_ready && rd_tc != 0 && (count + inflight) < FIFO_DEPTH.
  - Each issue decrements rd_tc; di_reg_data_out is pushed on the next cycle.
  - rdy = FIFO not empty; data_out = FIFO head.
  - Host pop on rdwr_b && rdy.
  - Push and pop in the same cycle: count unchanged; legal when full.
  - Pop when empty is ignored.
  - Issue is independent of rdwr_b; the host does not stall the device.
- WRDATA:
  - rdy = wr_ready && wr_tc != 0.
  - On rdwr_b && rdy: di_write=1, di_reg_data_in <= data_q, wr_tc decrements.
  - With wr_tc = 0, strobes are ignored and no write occurs.
- AUTO_INC=1: di_reg_addr increments by 1 on the cycle after each burst di_read or di_write, wrapping modulo 2^ADDR_W. Single GETRVAL/SETRVAL accesses never increment.
- Counters saturate at 0 and never wrap below 0.
- Reset asserted mid-burst: everything returns to 0 immediately; the FIFO contents are lost.

Decomposition:
- Package host_if_pkg holds:
  - opcode localparams: SETEP=1, SETREG=2, SETRVAL=3, RDDATA=4, RESETRVAL=5, GETRVAL=6, RDTC=7, WRDATA=8, WRTC=9;
  - the ctl bit index RDWR_B_BIT=1.
- One sub-module, host_if_rd_fifo: synchronous FIFO (DATA_W x FIFO_DEPTH) with push, pop, flush, count, empty and full, and asynchronous active-low reset on resetb.

Test Plan:
- SETEP with data 0x1234 then SETREG with 0x0042, one rdwr_b each -> di_ep_addr=0x1234, di_reg_addr=0x0042, rdy=1 throughout.
- RDTC=5, then RDDATA with rd_ready=1 and the host never strobing -> exactly 4 di_read pulses (FIFO full). Then 5 host pops -> 5 words in device order; rd_tc=0; rdy=0 after the last pop.
- RDTC=3, AUTO_INC=1, reg_addr=0xFFFF -> reads issued at addresses 0xFFFF, 0x0000, 0x0001; final di_reg_addr=0x0002.
- WRTC=2, WRDATA, 3 strobes with data 0xA, 0xB, 0xC and wr_ready=1 -> 2 di_write pulses (0xA, 0xB); third strobe ignored with rdy=0.
- RDDATA with 2 words buffered, then a switch to SETREG -> FIFO flushed, data_oe=0 one cycle after the change is registered, rd_tc unchanged.
- resetb pulsed low mid-WRDATA burst -> all outputs 0 asynchronously; after release no di_write occurs until WRTC is reloaded.

Source files
------------

// File: rtl/host_if_pkg.sv
// Shared opcode encodings and control-bus bit positions for the burst-capable
// host interface.
package host_if_pkg;

   localparam logic [3:0] SETEP     = 4'd1;
   localparam logic [3:0] SETREG    = 4'd2;
   localparam logic [3:0] SETRVAL   = 4'd3;
   localparam logic [3:0] RDDATA    = 4'd4;
   localparam logic [3:0] RESETRVAL = 4'd5;
   localparam logic [3:0] GETRVAL   = 4'd6;
   localparam logic [3:0] RDTC      = 4'd7;
   localparam logic [3:0] WRDATA    = 4'd8;
   localparam logic [3:0] WRTC      = 4'd9;

   localparam int RDWR_B_BIT = 1;

endpackage

// File: rtl/host_if_rd_fifo.sv
// Read prefetch FIFO.
// Push while full is accepted only when a pop happens in the same cycle.
module host_if_rd_fifo #(
   parameter int DATA_W     = 16,
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic              if_clock,
   input  logic              resetb,
   input  logic              push,
   input  logic              pop,
   input  logic              flush,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic [CNT_W-1:0]  count,
   output logic              empty,
   output logic              full
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);

   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              do_push, do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CNT_W'(FIFO_DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   always_ff @(posedge if_clock or negedge resetb) begin
      if (!resetb) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge if_clock) begin
      if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
   end

   assign rdata = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/host_if_burst.sv
// GPIF-style host interface: decodes host opcodes into register-bus single
// accesses and counted bursts, with a prefetching read path.
module host_if_burst
   import host_if_pkg::*;
#(
   parameter int DATA_W     = 16,
   parameter int ADDR_W     = 16,
   parameter int TC_W       = 16,
   parameter int FIFO_DEPTH = 4,
   parameter int AUTO_INC   = 0
) (
   input  logic              if_clock,
   input  logic              resetb,
   input  logic [2:0]        ctl,
   input  logic [3:0]        state,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              data_oe,
   output logic              rdy,
   output logic [ADDR_W-1:0] di_ep_addr,
   output logic [ADDR_W-1:0] di_reg_addr,
   output logic [DATA_W-1:0] di_reg_data_in,
   input  logic [DATA_W-1:0] di_reg_data_out,
   output logic              di_write,
   output logic              di_read,
   output logic              di_reset,
   input  logic              rd_ready,
   input  logic              wr_ready
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic [3:0]        state_q, state_qq;
   logic [2:0]        ctl_q;
   logic [DATA_W-1:0] data_q;
   logic [ADDR_W-1:0] ep_addr_q, ep_addr_d, reg_addr_q, reg_addr_d;
   logic [DATA_W-1:0] reg_data_q, reg_data_d;
   logic [TC_W-1:0]   rd_tc_q, rd_tc_d, wr_tc_q, wr_tc_d;
   logic              di_write_q, di_write_d, di_reset_q, di_reset_d;
   logic              data_oe_q, data_oe_d, inflight_q, inflight_d;
   logic              first_q, first_d, wr_burst_q, wr_burst_d;
   logic              chg, rdwr_b, rd_issue, single_rd, fifo_pop;
   logic              fifo_empty, fifo_full;
   logic [CNT_W-1:0]  fifo_count;
   logic [DATA_W-1:0] fifo_rdata;
   logic              ctl_unused;

   assign chg        = (state_q != state_qq);
   assign rdwr_b     = ctl_q[RDWR_B_BIT];
   assign ctl_unused = ^{ctl_q[2], ctl_q[0], fifo_full};

   host_if_rd_fifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH),
      .CNT_W      (CNT_W)
   ) u_rd_fifo (
      .if_clock (if_clock),
      .resetb   (resetb),
      .push     (inflight_q),
      .pop      (fifo_pop),
      .flush    (chg),
      .wdata    (di_reg_data_out),
      .rdata    (fifo_rdata),
      .count    (fifo_count),
      .empty    (fifo_empty),
      .full     (fifo_full)
   );

   always_comb begin
      ep_addr_d  = ep_addr_q;
      reg_addr_d = reg_addr_q;
      reg_data_d = reg_data_q;
      rd_tc_d    = rd_tc_q;
      wr_tc_d    = wr_tc_q;
      di_write_d = 1'b0;
      di_reset_d = 1'b0;
      data_oe_d  = 1'b0;
      inflight_d = 1'b0;
      wr_burst_d = 1'b0;
      first_d    = chg;
      rdy        = 1'b0;
      rd_issue   = 1'b0;
      single_rd  = 1'b0;
      fifo_pop   = 1'b0;
      // A burst write is visible on the bus for one cycle; step the address after it.
      if (AUTO_INC != 0 && wr_burst_q) reg_addr_d = reg_addr_q + 1'b1;
      if (!chg) begin
         case (state_q)
            SETEP: begin
               rdy = 1'b1;
               if (rdwr_b) ep_addr_d = ADDR_W'(data_q);
            end
            SETREG: begin
               rdy = 1'b1;
               if (rdwr_b) reg_addr_d = ADDR_W'(data_q);
            end
            SETRVAL: begin
               rdy = wr_ready;
               if (rdwr_b && wr_ready) begin
                  di_write_d = 1'b1;
                  reg_data_d = data_q;
               end
            end
            RESETRVAL: di_reset_d = first_q;
            GETRVAL: begin
               data_oe_d = 1'b1;
               rdy       = rd_ready;
               single_rd = rdwr_b && rd_ready;
            end
            RDTC: begin
               rdy = 1'b1;
               if (rdwr_b) rd_tc_d = TC_W'(data_q);
            end
            WRTC: begin
               rdy = 1'b1;
               if (rdwr_b) wr_tc_d = TC_W'(data_q);
            end
            RDDATA: begin
               data_oe_d = 1'b1;
               rdy       = !fifo_empty;
               fifo_pop  = rdwr_b && !fifo_empty;
               // Reserve a slot for the word still on its way from the device.
               rd_issue  = rd_ready && (rd_tc_q != '0) &&
                           ((fifo_count + CNT_W'(inflight_q)) < CNT_W'(FIFO_DEPTH));
               if (rd_issue) begin
                  rd_tc_d    = rd_tc_q - 1'b1;
                  inflight_d = 1'b1;
                  if (AUTO_INC != 0) reg_addr_d = reg_addr_q + 1'b1;
               end
            end
            WRDATA: begin
               rdy = wr_ready && (wr_tc_q != '0);
               if (rdwr_b && rdy) begin
                  di_write_d = 1'b1;
                  reg_data_d = data_q;
                  wr_tc_d    = wr_tc_q - 1'b1;
                  wr_burst_d = 1'b1;
               end
            end
            default: rdy = 1'b0;
         endcase
      end
   end

   always_ff @(posedge if_clock or negedge resetb) begin
      if (!resetb) begin
         state_q    <= '0;
         state_qq   <= '0;
         ctl_q      <= '0;
         data_q     <= '0;
         ep_addr_q  <= '0;
         reg_addr_q <= '0;
         reg_data_q <= '0;
         rd_tc_q    <= '0;
         wr_tc_q    <= '0;
         di_write_q <= 1'b0;
         di_reset_q <= 1'b0;
         data_oe_q  <= 1'b0;
         inflight_q <= 1'b0;
         first_q    <= 1'b0;
         wr_burst_q <= 1'b0;
      end else begin
         state_q    <= state;
         state_qq   <= state_q;
         ctl_q      <= ctl;
         data_q     <= data_in;
         ep_addr_q  <= ep_addr_d;
         reg_addr_q <= reg_addr_d;
         reg_data_q <= reg_data_d;
         rd_tc_q    <= rd_tc_d;
         wr_tc_q    <= wr_tc_d;
         di_write_q <= di_write_d;
         di_reset_q <= di_reset_d;
         data_oe_q  <= data_oe_d;
         inflight_q <= inflight_d;
         first_q    <= first_d;
         wr_burst_q <= wr_burst_d;
      end
   end

   assign data_out = (state_q == GETRVAL) ? di_reg_data_out :
                     (state_q == RDDATA && !fifo_empty) ? fifo_rdata : '0;
   assign data_oe        = data_oe_q;
   assign di_ep_addr     = ep_addr_q;
   assign di_reg_addr    = reg_addr_q;
   assign di_reg_data_in = reg_data_q;
   assign di_write       = di_write_q;
   assign di_reset       = di_reset_q;
   assign di_read        = rd_issue | single_rd;

endmodule

// File: tb/tb_host_if_burst.sv
// Directed bench for host_if_burst with a device model feeding read and write
// scoreboards.
module tb_host_if_burst;
   import host_if_pkg::*;

   logic        if_clock = 1'b0;
   logic        resetb = 1'b0;
   logic [2:0]  ctl = '0;
   logic [3:0]  state = '0;
   logic [15:0] data_in = '0;
   logic [15:0] di_reg_data_out = 16'hD000;
   logic        rd_ready = 1'b0;
   logic        wr_ready = 1'b0;
   logic [15:0] data_out, di_ep_addr, di_reg_addr, di_reg_data_in;
   logic        data_oe, rdy, di_write, di_read, di_reset;

   int          n_assert = 0;
   int          n_fail = 0;
   int          rd_cnt = 0;
   int          wr_cnt = 0;
   int          rst_cnt = 0;
   int          base;
   logic [15:0] dev_val = 16'hD000;
   logic [15:0] addr0;
   logic [15:0] rd_exp_q[$];
   logic [15:0] rd_addr_q[$];
   logic [15:0] wr_exp_q[$];

   host_if_burst #(
      .DATA_W     (16),
      .ADDR_W     (16),
      .TC_W       (16),
      .FIFO_DEPTH (4),
      .AUTO_INC   (1)
   ) dut (
      .if_clock        (if_clock),
      .resetb          (resetb),
      .ctl             (ctl),
      .state           (state),
      .data_in         (data_in),
      .data_out        (data_out),
      .data_oe         (data_oe),
      .rdy             (rdy),
      .di_ep_addr      (di_ep_addr),
      .di_reg_addr     (di_reg_addr),
      .di_reg_data_in  (di_reg_data_in),
      .di_reg_data_out (di_reg_data_out),
      .di_write        (di_write),
      .di_read         (di_read),
      .di_reset        (di_reset),
      .rd_ready        (rd_ready),
      .wr_ready        (wr_ready)
   );

   always #5 if_clock = ~if_clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Device model: answers each read one cycle later and checks each write.
   always begin
      logic rd_seen;
      @(negedge if_clock);
      rd_seen = di_read;
      if (di_read) begin
         rd_cnt++;
         dev_val = dev_val + 16'd1;
         rd_exp_q.push_back(dev_val);
         rd_addr_q.push_back(di_reg_addr);
      end
      if (di_write) begin
         wr_cnt++;
         if (wr_exp_q.size() == 0) check("unexpected_write", 32'(di_reg_data_in), 32'hFFFF_FFFF);
         else check("wr_data", 32'(di_reg_data_in), 32'(wr_exp_q.pop_front()));
      end
      if (di_reset) rst_cnt++;
      @(posedge if_clock);
      #1;
      if (rd_seen) di_reg_data_out = dev_val;
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic cyc();
      @(posedge if_clock);
      #1;
   endtask

   task automatic set_op(input logic [3:0] op);
      state = op;
      ctl   = '0;
      repeat (3) cyc();
   endtask

   task automatic strobe(input logic [15:0] d);
      data_in = d;
      ctl     = 3'b010;
      cyc();
      ctl = '0;
      cyc();
      cyc();
   endtask

   task automatic host_pop(input string tag);
      int n = 0;
      while (rdy !== 1'b1 && n < 20) begin
         cyc();
         n++;
      end
      check({tag, "_rdy_wait"}, 32'(rdy), 32'd1);
      if (rdy === 1'b1) begin
         if (rd_exp_q.size() == 0) check({tag, "_no_expect"}, 32'(data_out), 32'hFFFF_FFFF);
         else check(tag, 32'(data_out), 32'(rd_exp_q.pop_front()));
         ctl = 3'b010;
         cyc();
         ctl = '0;
         cyc();
      end
   endtask

   initial begin
      #1;
      check("rst_rdy", 32'(rdy), 32'd0);
      check("rst_oe", 32'(data_oe), 32'd0);
      check("rst_strobes", 32'({di_write, di_read, di_reset}), 32'd0);
      check("rst_addrs", {di_ep_addr, di_reg_addr}, 32'd0);
      check("rst_data", {data_out, di_reg_data_in}, 32'd0);
      repeat (2) cyc();
      resetb = 1'b1;
      cyc();

      // Address loads
      set_op(SETEP);
      check("setep_rdy", 32'(rdy), 32'd1);
      strobe(16'h1234);
      check("ep_addr", 32'(di_ep_addr), 32'h1234);
      set_op(SETREG);
      strobe(16'h0042);
      check("reg_addr", 32'(di_reg_addr), 32'h0042);
      check("setreg_rdy", 32'(rdy), 32'd1);

      // Single set / get never step the address
      wr_ready = 1'b1;
      set_op(SETRVAL);
      check("setrval_rdy", 32'(rdy), 32'd1);
      base = wr_cnt;
      wr_exp_q.push_back(16'h5A5A);
      strobe(16'h5A5A);
      check("setrval_writes", 32'(wr_cnt - base), 32'd1);
      check("setrval_no_inc", 32'(di_reg_addr), 32'h0042);
      rd_ready = 1'b1;
      set_op(GETRVAL);
      @(negedge if_clock);
      check("getrval_oe", 32'(data_oe), 32'd1);
      check("getrval_data", 32'(data_out), 32'(dev_val));
      cyc();
      base = rd_cnt;
      strobe(16'h0000);
      check("getrval_reads", 32'(rd_cnt - base), 32'd1);
      check("getrval_no_inc", 32'(di_reg_addr), 32'h0042);
      rd_exp_q.delete();
      rd_addr_q.delete();

      // Register reset pulse lasts one cycle
      base = rst_cnt;
      set_op(RESETRVAL);
      repeat (3) cyc();
      check("di_reset_pulses", 32'(rst_cnt - base), 32'd1);

      // Prefetch fills the FIFO then drains in device order
      rd_ready = 1'b0;
      set_op(RDTC);
      strobe(16'd5);
      rd_ready = 1'b1;
      base = rd_cnt;
      set_op(RDDATA);
      repeat (10) cyc();
      check("prefetch_reads", 32'(rd_cnt - base), 32'd4);
      check("prefetch_rdy", 32'(rdy), 32'd1);
      check("prefetch_oe", 32'(data_oe), 32'd1);
      for (int i = 0; i < 5; i++) host_pop("burst_pop");
      repeat (3) cyc();
      check("burst_drained_rdy", 32'(rdy), 32'd0);
      check("burst_total_reads", 32'(rd_cnt - base), 32'd5);

      // Auto-increment wraps the register address
      set_op(SETREG);
      strobe(16'hFFFF);
      check("reg_addr_ffff", 32'(di_reg_addr), 32'hFFFF);
      set_op(RDTC);
      strobe(16'd3);
      rd_exp_q.delete();
      rd_addr_q.delete();
      base = rd_cnt;
      set_op(RDDATA);
      repeat (8) cyc();
      check("wrap_reads", 32'(rd_cnt - base), 32'd3);
      check("wrap_addr0", rd_addr_q.size() > 0 ? 32'(rd_addr_q.pop_front()) : 32'hDEAD, 32'hFFFF);
      check("wrap_addr1", rd_addr_q.size() > 0 ? 32'(rd_addr_q.pop_front()) : 32'hDEAD, 32'h0000);
      check("wrap_addr2", rd_addr_q.size() > 0 ? 32'(rd_addr_q.pop_front()) : 32'hDEAD, 32'h0001);
      check("wrap_final_addr", 32'(di_reg_addr), 32'h0002);

      // Opcode change flushes buffered words but keeps the read counter
      rd_ready = 1'b0;
      set_op(SETREG);
      rd_exp_q.delete();
      set_op(RDTC);
      strobe(16'd4);
      set_op(RDDATA);
      base = rd_cnt;
      rd_ready = 1'b1;
      cyc();
      cyc();
      rd_ready = 1'b0;
      repeat (3) cyc();
      check("flush_pre_reads", 32'(rd_cnt - base), 32'd2);
      check("flush_pre_rdy", 32'(rdy), 32'd1);
      state = SETREG;
      cyc();
      cyc();
      check("flush_oe_off", 32'(data_oe), 32'd0);
      rd_exp_q.delete();
      base = rd_cnt;
      rd_ready = 1'b1;
      set_op(RDDATA);
      repeat (4) cyc();
      check("flush_rest_reads", 32'(rd_cnt - base), 32'd2);
      host_pop("flush_pop");
      host_pop("flush_pop");
      repeat (3) cyc();
      check("flush_drained_rdy", 32'(rdy), 32'd0);

      // Write burst limited by the write counter
      rd_ready = 1'b0;
      set_op(WRTC);
      strobe(16'd2);
      set_op(WRDATA);
      base  = wr_cnt;
      addr0 = di_reg_addr;
      check("wrdata_rdy", 32'(rdy), 32'd1);
      wr_exp_q.push_back(16'h000A);
      strobe(16'h000A);
      wr_exp_q.push_back(16'h000B);
      strobe(16'h000B);
      check("wrdata_exhausted_rdy", 32'(rdy), 32'd0);
      strobe(16'h000C);
      repeat (2) cyc();
      check("wrdata_writes", 32'(wr_cnt - base), 32'd2);
      check("wrdata_addr_inc", 32'(di_reg_addr), 32'(addr0 + 16'd2));

      // Asynchronous reset in the middle of a write burst
      set_op(WRTC);
      strobe(16'd3);
      set_op(WRDATA);
      wr_exp_q.push_back(16'h0111);
      strobe(16'h0111);
      base = wr_cnt;
      data_in = 16'h0222;
      ctl = 3'b010;
      cyc();
      ctl = '0;
      cyc();
      check("midburst_write_live", 32'(di_write), 32'd1);
      #1 resetb = 1'b0;
      #1;
      check("async_rst_strobes", 32'({di_write, di_read, di_reset, data_oe, rdy}), 32'd0);
      check("async_rst_addrs", {di_ep_addr, di_reg_addr}, 32'd0);
      check("async_rst_data", {data_out, di_reg_data_in}, 32'd0);
      cyc();
      resetb = 1'b1;
      repeat (4) cyc();
      check("post_rst_rdy", 32'(rdy), 32'd0);
      strobe(16'h0333);
      check("post_rst_no_write", 32'(wr_cnt - base), 32'd0);
      set_op(WRTC);
      strobe(16'd1);
      set_op(WRDATA);
      check("reload_rdy", 32'(rdy), 32'd1);
      wr_exp_q.push_back(16'h0444);
      strobe(16'h0444);
      check("reload_write", 32'(wr_cnt - base), 32'd1);
      check("wr_queue_empty", 32'(wr_exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
